// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared definitions for the staged reset sequencer.
//   seq_state_e : FSM state enum and encodings (HOLD, REL, RUN)
//   cnt_width() : width of a counter holding values 0 .. n-1 (minimum 1 bit)
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_REL  = 2'b01,
    ST_RUN  = 2'b10
  } seq_state_e;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// rst_sync: reset synchronizer. Asserts asynchronously, releases
// synchronously after SYNC_STAGES rising edges of clk_i.
//   clk_i    : clock
//   arst_n_i : raw asynchronous active-low reset
//   rst_n_o  : synchronized active-low reset
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_n_i,
  output logic rst_n_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged release of NUM_CH active-high reset channels.
// After the synchronized reset releases, all channels are held for
// HOLD_CYCLES edges, then released one by one in ascending order,
// STAGE_GAP edges apart. sw_req re-runs the whole sequence.
//
// Optional feature macro: RST_SEQ_WDOG_EN adds a RUN-state watchdog
// (parameter WDOG_LIMIT, ports wdog_kick / wdog_to) that re-sequences
// when no kick arrives within WDOG_LIMIT edges.
//
// Ports:
//   clk       : sole clock, rising edge
//   reset     : asynchronous active-low reset
//   sw_req    : single-cycle request to re-run the sequence
//   ch_reset  : per-channel active-high reset outputs
//   busy      : high while any channel is asserted (always ~done)
//   done      : high while all channels are released
//   cycle_cnt : edges spent in RUN since the last release, saturating
//   wdog_kick : (RST_SEQ_WDOG_EN) watchdog kick
//   wdog_to   : (RST_SEQ_WDOG_EN) sticky watchdog timeout flag
//
// state | meaning
// HOLD  | all channels asserted, counting HOLD_CYCLES
// REL   | releasing channels one per STAGE_GAP edges
// RUN   | all channels released, cycle_cnt counting
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGE_GAP   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
`ifdef RST_SEQ_WDOG_EN
  ,
  parameter int WDOG_LIMIT  = 1000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_req,
`ifdef RST_SEQ_WDOG_EN
  input  logic              wdog_kick,
  output logic              wdog_to,
`endif
  output logic [NUM_CH-1:0] ch_reset,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int GAP_W  = cnt_width(STAGE_GAP);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  // Channels release as a shifting thermometer; the last release happens
  // when only the top bit is still set.
  localparam logic [NUM_CH-1:0] LAST_CH   = NUM_CH'(1) << (NUM_CH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic              rst_sync_n;
  logic              reseq;
  seq_state_e        state_q;
  logic              armed_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [NUM_CH-1:0] ch_reset_q;
  logic              done_q;
  logic [CNT_W-1:0]  cycle_cnt_q;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk_i    (clk),
    .arst_n_i (reset),
    .rst_n_o  (rst_sync_n)
  );

`ifdef RST_SEQ_WDOG_EN
  localparam int WDOG_W = cnt_width(WDOG_LIMIT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              wdog_to_q;
  logic              wdog_fire;

  // A kick on the limit edge wins over the timeout.
  assign wdog_fire = (state_q == ST_RUN) && !wdog_kick && (wdog_cnt_q == WDOG_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_cnt_q <= '0;
      wdog_to_q  <= 1'b0;
    end else begin
      if ((state_q != ST_RUN) || wdog_kick || wdog_fire) begin
        wdog_cnt_q <= '0;
      end else begin
        wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
      end
      if (wdog_fire) begin
        wdog_to_q <= 1'b1;
      end
    end
  end

  assign reseq   = sw_req | wdog_fire;
  assign wdog_to = wdog_to_q;
`else
  assign reseq = sw_req;
`endif

  // armed_q delays counting by one edge after the synchronizer releases, so
  // the release edge behaves like the edge of a re-sequence request and the
  // first channel drops on edge SYNC_STAGES + HOLD_CYCLES.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HOLD;
      armed_q     <= 1'b0;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      ch_reset_q  <= '1;
      done_q      <= 1'b0;
      cycle_cnt_q <= '0;
    end else if (!rst_sync_n || reseq) begin
      state_q     <= ST_HOLD;
      armed_q     <= rst_sync_n;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      ch_reset_q  <= '1;
      done_q      <= 1'b0;
      cycle_cnt_q <= '0;
    end else if (!armed_q) begin
      armed_q <= 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            ch_reset_q <= ch_reset_q << 1;
            if (ch_reset_q == LAST_CH) begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_REL;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_REL: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q  <= '0;
            ch_reset_q <= ch_reset_q << 1;
            if (ch_reset_q == LAST_CH) begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        ST_RUN: begin
          if (cycle_cnt_q != CNT_MAX) begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q     <= ST_HOLD;
          hold_cnt_q  <= '0;
          gap_cnt_q   <= '0;
          ch_reset_q  <= '1;
          done_q      <= 1'b0;
          cycle_cnt_q <= '0;
        end
      endcase
    end
  end

  assign ch_reset  = ch_reset_q;
  assign done      = done_q;
  assign busy      = ~done_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer.
// dut_a: NUM_CH=3, HOLD_CYCLES=10, STAGE_GAP=4, SYNC_STAGES=2, CNT_W=32
// dut_b: NUM_CH=1, HOLD_CYCLES=3, CNT_W=4 (direct HOLD->RUN, saturation)
// With RST_SEQ_WDOG_EN defined, dut_a uses WDOG_LIMIT=8.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sw_req_a;
  logic        sw_req_b;
  logic [2:0]  ch_a;
  logic        busy_a;
  logic        done_a;
  logic [31:0] cnt_a;
  logic [0:0]  ch_b;
  logic        busy_b;
  logic        done_b;
  logic [3:0]  cnt_b;

`ifdef RST_SEQ_WDOG_EN
  logic kick;
  logic wdog_to_a;
  logic wdog_to_b;
  bit   kick_en;
  int   kick_ph;
`endif

  int n_chk = 0;
  int n_bad = 0;

  reset_sequencer #(
    .NUM_CH(3), .HOLD_CYCLES(10), .STAGE_GAP(4), .SYNC_STAGES(2), .CNT_W(32)
`ifdef RST_SEQ_WDOG_EN
    , .WDOG_LIMIT(8)
`endif
  ) dut_a (
    .clk       (clk),
    .reset     (reset),
    .sw_req    (sw_req_a),
`ifdef RST_SEQ_WDOG_EN
    .wdog_kick (kick),
    .wdog_to   (wdog_to_a),
`endif
    .ch_reset  (ch_a),
    .busy      (busy_a),
    .done      (done_a),
    .cycle_cnt (cnt_a)
  );

  reset_sequencer #(
    .NUM_CH(1), .HOLD_CYCLES(3), .STAGE_GAP(4), .SYNC_STAGES(2), .CNT_W(4)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .sw_req    (sw_req_b),
`ifdef RST_SEQ_WDOG_EN
    .wdog_kick (kick),
    .wdog_to   (wdog_to_b),
`endif
    .ch_reset  (ch_b),
    .busy      (busy_b),
    .done      (done_b),
    .cycle_cnt (cnt_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; sample point is 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
`ifdef RST_SEQ_WDOG_EN
      kick_ph = (kick_ph == 4) ? 0 : kick_ph + 1;
      kick    = kick_en && (kick_ph == 4);
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_ch;
    reset    = 1'b0;
    sw_req_a = 1'b0;
    sw_req_b = 1'b0;
`ifdef RST_SEQ_WDOG_EN
    kick     = 1'b0;
    kick_en  = 1'b1;
    kick_ph  = 0;
`endif

    // In reset
    step(3);
    check_val("rst_ch_a",   32'(ch_a),   32'd7);
    check_val("rst_busy_a", 32'(busy_a), 32'd1);
    check_val("rst_done_a", 32'(done_a), 32'd0);
    check_val("rst_cnt_a",  cnt_a,       32'd0);
    check_val("rst_ch_b",   32'(ch_b),   32'd1);

    // Release before edge 0: [0] at 12, [1] at 16, [2] at 20
    reset = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step(1);
      exp_ch = (k < 12) ? 7 : (k < 16) ? 6 : (k < 20) ? 4 : 0;
      check_val($sformatf("seq_ch_a@%0d", k), 32'(ch_a), 32'(exp_ch));
      if (k == 4)  check_val("b_done@4",  32'(done_b), 32'd0);
      if (k == 5)  check_val("b_done@5",  32'(done_b), 32'd1);
      if (k == 5)  check_val("b_ch@5",    32'(ch_b),   32'd0);
      if (k == 12) check_val("b_cnt@12",  32'(cnt_b),  32'd7);
      if (k == 19) check_val("done_a@19", 32'(done_a), 32'd0);
    end
    check_val("done_a@20", 32'(done_a), 32'd1);
    check_val("busy_a@20", 32'(busy_a), 32'd0);
    check_val("cnt_a@20",  cnt_a,       32'd0);
    check_val("b_cnt@20",  32'(cnt_b),  32'd15);

    // RUN for 25 more edges (edge 45)
    step(25);
    check_val("cnt_a@45",  cnt_a,       32'd25);
    check_val("done_a@45", 32'(done_a), 32'd1);
    check_val("b_cnt_sat", 32'(cnt_b),  32'd15);
    check_val("b_busy",    32'(busy_b), 32'd0);
`ifdef RST_SEQ_WDOG_EN
    check_val("wdog_kicked", 32'(wdog_to_a), 32'd0);
`endif

    // sw_req in RUN at edge E
    sw_req_a = 1'b1;
    step(1);
    sw_req_a = 1'b0;
    check_val("sw_ch_a",   32'(ch_a),   32'd7);
    check_val("sw_cnt_a",  cnt_a,       32'd0);
    check_val("sw_done_a", 32'(done_a), 32'd0);
    check_val("sw_busy_a", 32'(busy_a), 32'd1);
    step(9);
    check_val("sw_ch_a@E+9", 32'(ch_a), 32'd7);
    step(1);
    check_val("sw_ch_a@E+10", 32'(ch_a), 32'd6);

    // sw_req in REL at edge F
    step(1);
    sw_req_a = 1'b1;
    step(1);
    sw_req_a = 1'b0;
    check_val("rel_sw_ch_a", 32'(ch_a), 32'd7);

    // sw_req with hold count at 5
    step(5);
    sw_req_a = 1'b1;
    step(1);
    sw_req_a = 1'b0;
    step(9);
    check_val("hold_sw_ch@+9",  32'(ch_a), 32'd7);
    step(1);
    check_val("hold_sw_ch@+10", 32'(ch_a), 32'd6);
    step(4);
    check_val("hold_sw_ch@+14", 32'(ch_a), 32'd4);
    step(2);

    // Asynchronous reset mid-REL
    reset = 1'b0;
    #1;
    check_val("arst_ch_a",   32'(ch_a),   32'd7);
    check_val("arst_done_a", 32'(done_a), 32'd0);
    check_val("arst_busy_a", 32'(busy_a), 32'd1);
    check_val("arst_cnt_b",  32'(cnt_b),  32'd0);
    check_val("arst_ch_b",   32'(ch_b),   32'd1);
    step(2);
`ifdef RST_SEQ_WDOG_EN
    kick_en = 1'b0;
`endif
    reset = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step(1);
      if (k == 11) check_val("restart_ch@11", 32'(ch_a), 32'd7);
      if (k == 12) check_val("restart_ch@12", 32'(ch_a), 32'd6);
      if (k == 20) check_val("restart_ch@20", 32'(ch_a), 32'd0);
    end
    check_val("restart_done", 32'(done_a), 32'd1);

`ifdef RST_SEQ_WDOG_EN
    check_val("wdog_to@20", 32'(wdog_to_a), 32'd0);
    step(7);
    check_val("wdog_to@27",  32'(wdog_to_a), 32'd0);
    check_val("wdog_cnt@27", cnt_a,          32'd7);
    check_val("wdog_done@27", 32'(done_a),   32'd1);
    step(1);
    check_val("wdog_to@28",   32'(wdog_to_a), 32'd1);
    check_val("wdog_ch@28",   32'(ch_a),      32'd7);
    check_val("wdog_done@28", 32'(done_a),    32'd0);
    check_val("wdog_cnt@28",  cnt_a,          32'd0);
    step(10);
    check_val("wdog_ch@38",     32'(ch_a),      32'd6);
    check_val("wdog_sticky@38", 32'(wdog_to_a), 32'd1);
`else
    step(3);
    check_val("restart_cnt@23", cnt_a, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of staged reset channels (1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 10, cycles all channels stay asserted after synchronized release (>=1).
REQ-003 SHALL have parameter STAGE_GAP, default 4, cycles between successive channel releases (>=1).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, reset synchronizer depth (>=2).
REQ-005 SHALL have parameter CNT_W, default 32, width of cycle_cnt.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-008 SHALL have port sw_req  input  1  single-cycle request to re-run the sequence.
REQ-009 SHALL have port ch_reset  output  NUM_CH  per-channel active-high reset to downstream cores.
REQ-010 SHALL have port busy  output  1  high while any channel is asserted.
REQ-011 SHALL have port done  output  1  high while all channels are released.
REQ-012 SHALL have port cycle_cnt  output  CNT_W  edges spent in RUN since last release.

Function
REQ-013 SHALL implement FSM states HOLD, REL, RUN; HOLD entered on reset and on any re-sequence.
REQ-014 SHALL pass reset through a SYNC_STAGES flop chain: asynchronous assertion, synchronous deassertion.
REQ-015 SHALL hold the FSM in HOLD with hold count 0 while the synchronized reset is low.
REQ-016 In HOLD, SHALL increment hold count each edge; on the edge where count == HOLD_CYCLES-1, SHALL clear ch_reset[0] and enter REL.
REQ-017 In REL, SHALL clear ch_reset[k] exactly STAGE_GAP edges after ch_reset[k-1]; release order is strictly ascending index.
REQ-018 On the edge clearing ch_reset[NUM_CH-1], SHALL enter RUN and set done=1, busy=0; NUM_CH=1 enters RUN directly from HOLD.
REQ-019 SHALL keep busy = ~done at all times.
REQ-020 In RUN, cycle_cnt SHALL increment by 1 per edge and saturate at all-ones; cleared to 0 on entry to HOLD.
REQ-021 sw_req sampled high in RUN or REL SHALL, at that edge, set all ch_reset to 1, done=0, enter HOLD with count 0.
REQ-022 sw_req sampled high in HOLD SHALL restart the hold count at 0; sw_req ignored while synchronized reset is low.
REQ-023 Timing: first channel releases on edge SYNC_STAGES+HOLD_CYCLES after reset deassertion; after sw_req at edge E, on edge E+HOLD_CYCLES.

Reset
REQ-024 Asserting reset SHALL immediately (asynchronously) force ch_reset all-ones, busy=1, done=0, cycle_cnt=0, state HOLD, in any state including mid-REL.
REQ-025 No output SHALL glitch low during reset assertion or within SYNC_STAGES edges after deassertion.

Configuration
REQ-026 Macro RST_SEQ_WDOG_EN defined SHALL add parameter WDOG_LIMIT (default 1000), input wdog_kick (1 bit) and output wdog_to (1 bit).
REQ-027 With RST_SEQ_WDOG_EN: in RUN, a watchdog counter SHALL count edges since last wdog_kick; reaching WDOG_LIMIT SHALL set sticky wdog_to and re-sequence as if sw_req; wdog_to cleared only by reset; kick and limit on same edge = kick wins.
REQ-028 Without RST_SEQ_WDOG_EN: ports and watchdog logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 SHALL place FSM state enum and state encodings in shared package rst_seq_pkg.
REQ-030 SHALL implement the synchronizer as sub-module rst_sync (parameter SYNC_STAGES), instantiated once.

Verification
REQ-031 NUM_CH=3, HOLD_CYCLES=10, STAGE_GAP=4, SYNC_STAGES=2, reset released before edge 0 -> ch_reset[0] falls edge 12, [1] edge 16, [2] edge 20; done=1 from edge 20.
REQ-032 Same config, reset asserted between edges 14 and 15 -> ch_reset=3'b111 immediately, done=0, sequence restarts 12 edges after release.
REQ-033 In RUN, cycle_cnt=25, sw_req at edge E -> ch_reset=3'b111 at E, cycle_cnt=0, ch_reset[0] falls edge E+10.
REQ-034 sw_req pulsed at hold count 5 -> hold restarts; ch_reset[0] falls 10 edges after pulse.
REQ-035 CNT_W=4, run 20 edges in RUN -> cycle_cnt stays 4'hF.
REQ-036 RST_SEQ_WDOG_EN, WDOG_LIMIT=8, no kicks -> wdog_to=1 and full re-sequence at 8th RUN edge; with kick every 5 edges -> wdog_to stays 0.
